sipo_shift_reg: RTL and testbench
=================================

Name: sipo_shift_reg

Overview:
- Parameterised serial-in, parallel-out shift register.
- Captures one serial bit per enabled clock edge and presents the last WIDTH bits in parallel.
- Flags each completed WIDTH-bit word with a one-cycle valid pulse.
- Sits between a serial bit source (e.g. a deserialiser front end) and word-oriented downstream logic.

Parameters:
- WIDTH, 4, parallel output width in bits; legal range WIDTH >= 2.
- SHIFT_LEFT, 1, 1 = new bit enters at q[0] and older bits move toward q[WIDTH-1]; 0 = new bit enters at q[WIDTH-1] and older bits move toward q[0].

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  shift enable; tie to 1 for free-running shifting.
- d  input  1  serial data bit, sampled on the rising clk edge when en=1.
- q  output  WIDTH  parallel register contents.
- valid  output  1  one-cycle pulse marking a completed WIDTH-bit word.
- bit_cnt  output  clog2(WIDTH)  number of bits shifted into the current word, range 0..WIDTH-1.

Behaviour:
- Single clock domain. All outputs are registered; there is no combinational path from inputs to outputs.
- Reset:
  - rst=1 at a rising edge sets q=0, bit_cnt=0, valid=0.
  - rst has priority over en and d.
  - Until the first reset edge, outputs are undefined; the bench applies reset first.
- Shift, when rst=0 and en=1, each rising edge:
  - SHIFT_LEFT=1: q <= {q[WIDTH-2:0], d}.
  - SHIFT_LEFT=0: q <= {d, q[WIDTH-1:1]}.
- Hold: when rst=0 and en=0, q and bit_cnt keep their values and valid <= 0.
- Latency: d sampled at edge N is visible on q immediately after edge N, i.e. one cycle.
- Bit counter:
  - Increments on every enabled shift.
  - On the enabled shift where bit_cnt == WIDTH-1, bit_cnt wraps to 0 and valid <= 1 for exactly one cycle.
  - On all other edges, valid <= 0.
- Valid timing:
  - valid is high in the cycle immediately after the edge that shifted in the WIDTH-th bit of a word.
  - While valid is high, q holds that complete word.
  - Consecutive words with en held high produce valid pulses exactly WIDTH cycles apart and no gap in shifting.
- q is a sliding window: it changes on every enabled shift, not only at word boundaries. Consumers sample q when valid=1.
- Gaps in en stretch word assembly; bit_cnt resumes counting from its held value.
- Reset mid-word discards partial bits: bit_cnt=0, q=0, and no valid pulse is produced for the aborted word.
- Reset on the same edge as the WIDTH-th bit: reset wins and valid stays 0.
- No handshake or backpressure: a word not sampled during its valid cycle is overwritten by subsequent shifts.

Test Plan:
- Reset then stream (WIDTH=4, SHIFT_LEFT=1, en=1): d=1,0,1,1 on four consecutive edges -> q=0001, 0010, 0101, 1011 after each edge; bit_cnt=1,2,3,0; valid=1 only in the cycle after the 4th edge, with q=1011.
- Right-shift variant (SHIFT_LEFT=0): same d sequence -> q=1000, 0100, 1010, 1101; valid pulse in the cycle after the 4th edge.
- Enable gating: shift d=1,1, drop en for 3 cycles with d toggling, then shift d=0,0 -> q=0011 held during the gap, final q=1100; valid fires only after the 4th enabled bit.
- Continuous stream of 12 bits with en=1 -> exactly 3 valid pulses, 4 cycles apart; q at each pulse equals the last 4 bits sent.
- Reset mid-word: after 2 shifts assert rst for one edge -> q=0000, bit_cnt=0, no valid pulse; the next 4 bits form a full word with valid.
- Reset coincident with the 4th bit edge -> q=0000, bit_cnt=0, valid stays 0 in the following cycle.

Source files
------------

// File: rtl/sipo_shift_reg.sv
// ---------------------------------------------------------------------------
// sipo_shift_reg
// Serial-in, parallel-out shift register with word framing.
// One serial bit is captured per enabled clock edge. The register exposes the
// most recent WIDTH bits as a sliding window, and a bit counter tracks the
// position inside the current word. A one-cycle valid pulse follows the edge
// that completes each WIDTH-bit word, while q holds that complete word.
//
// SHIFT_LEFT = 1 : the new bit enters at q[0] and older bits move up.
// SHIFT_LEFT = 0 : the new bit enters at q[WIDTH-1] and older bits move down.
//
// All outputs come straight from flops. There is no combinational path from
// the inputs to the outputs.
// ---------------------------------------------------------------------------
module sipo_shift_reg #(
   parameter int WIDTH      = 4,
   parameter bit SHIFT_LEFT = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     d,
   output logic [WIDTH-1:0]         q,
   output logic                     valid,
   output logic [$clog2(WIDTH)-1:0] bit_cnt
);

   localparam int CNT_W = $clog2(WIDTH);

   // Counter value seen when the final bit of a word is shifted in.
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   logic [WIDTH-1:0] shreg_q;
   logic [WIDTH-1:0] shreg_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             valid_q;
   logic             valid_d;

   // Next-state logic: shift and count on enable, otherwise hold; valid only on word completion
   always_comb begin
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      valid_d = 1'b0;
      if (en) begin
         if (SHIFT_LEFT) begin
            shreg_d = {shreg_q[WIDTH-2:0], d};
         end else begin
            shreg_d = {d, shreg_q[WIDTH-1:1]};
         end
         // Wrap explicitly so that WIDTH values that are not a power of two also frame correctly.
         if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            valid_d = 1'b1;
         end else begin
            cnt_d   = cnt_q + 1'b1;
         end
      end
   end

   // State registers: synchronous reset takes priority over enable and data
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg_q <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
      end
   end

   assign q       = shreg_q;
   assign bit_cnt = cnt_q;
   assign valid   = valid_q;

endmodule

// File: tb/tb_sipo_shift_reg.sv
// ---------------------------------------------------------------------------
// tb_sipo_shift_reg
// Scoreboard bench for sipo_shift_reg. A left-shifting instance and a
// right-shifting instance (WIDTH=4) share the same stimulus. The reference
// model keeps the history of bits received since the last reset and a count
// of enabled shifts. From these it derives the expected window, the bit
// position and the word completions. Expectations are queued when stimulus is
// issued. A separate monitor pops them on the falling edge and compares.
// ---------------------------------------------------------------------------
module tb_sipo_shift_reg;

   localparam int W  = 4;
   localparam int CW = $clog2(W);

   logic          clk;
   logic          rst;
   logic          en;
   logic          d;
   logic [W-1:0]  q_l;
   logic [W-1:0]  q_r;
   logic          valid_l;
   logic          valid_r;
   logic [CW-1:0] cnt_l;
   logic [CW-1:0] cnt_r;

   sipo_shift_reg #(.WIDTH(W), .SHIFT_LEFT(1'b1)) dut_l (
      .clk(clk), .rst(rst), .en(en), .d(d),
      .q(q_l), .valid(valid_l), .bit_cnt(cnt_l)
   );

   sipo_shift_reg #(.WIDTH(W), .SHIFT_LEFT(1'b0)) dut_r (
      .clk(clk), .rst(rst), .en(en), .d(d),
      .q(q_r), .valid(valid_r), .bit_cnt(cnt_r)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0]  ql;
      logic [W-1:0]  qr;
      logic [CW-1:0] cnt;
      logic          vld;
   } exp_t;

   typedef struct packed {
      logic [W-1:0] ql;
      logic [W-1:0] qr;
   } word_t;

   exp_t  expq[$];
   word_t wq[$];

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state: bits received since the last reset, and the number of enabled shifts modulo W.
   bit hist[$];
   int mcnt = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Issue one clock of stimulus and queue the state expected after that edge.
   task automatic step(input logic r, input logic e, input logic b);
      exp_t x;
      bit   bt;
      rst = r;
      en  = e;
      d   = b;
      x   = '0;
      if (r) begin
         hist.delete();
         mcnt = 0;
      end else if (e) begin
         hist.push_back(b);
         if (hist.size() > W) void'(hist.pop_front());
         mcnt++;
         if (mcnt == W) begin
            mcnt  = 0;
            x.vld = 1'b1;
         end
      end
      // The i-th most recent bit sits at position i when shifting left, and at position W-1-i when shifting right.
      for (int i = 0; i < W; i++) begin
         bt = (hist.size() > i) ? hist[hist.size()-1-i] : 1'b0;
         x.ql[i]     = bt;
         x.qr[W-1-i] = bt;
      end
      x.cnt = CW'(mcnt);
      @(posedge clk);
      expq.push_back(x);
      if (x.vld) wq.push_back({x.ql, x.qr});
      #1;
   endtask

   // Monitor: compare the full state each cycle, and check the word delivered on each valid pulse.
   exp_t  mx;
   word_t mw;
   always @(negedge clk) begin
      if (expq.size() != 0) begin
         mx = expq.pop_front();
         chk("q_left",      32'(q_l),     32'(mx.ql));
         chk("q_right",     32'(q_r),     32'(mx.qr));
         chk("cnt_left",    32'(cnt_l),   32'(mx.cnt));
         chk("cnt_right",   32'(cnt_r),   32'(mx.cnt));
         chk("valid_left",  32'(valid_l), 32'(mx.vld));
         chk("valid_right", 32'(valid_r), 32'(mx.vld));
         if (valid_l === 1'b1) begin
            if (wq.size() == 0) begin
               chk("unexpected_word", 32'(1), 32'(0));
            end else begin
               mw = wq.pop_front();
               chk("word_left",  32'(q_l), 32'(mw.ql));
               chk("word_right", 32'(q_r), 32'(mw.qr));
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      en  = 1'b0;
      d   = 1'b0;

      // Reset, then stream 1,0,1,1 and idle for one cycle.
      step(1, 0, 0);
      step(0, 1, 1); step(0, 1, 0); step(0, 1, 1); step(0, 1, 1);
      step(0, 0, 0);

      // Enable gating: two bits, a three-cycle gap with d toggling, then two more bits.
      step(1, 0, 0);
      step(0, 1, 1); step(0, 1, 1);
      step(0, 0, 1); step(0, 0, 0); step(0, 0, 1);
      step(0, 1, 0); step(0, 1, 0);
      step(0, 0, 0);

      // Continuous stream of 12 random bits: three back-to-back words.
      step(1, 0, 0);
      for (int i = 0; i < 12; i++) step(0, 1, 1'($urandom_range(0, 1)));
      step(0, 0, 0);

      // Reset mid-word, then a full word.
      step(1, 0, 0);
      step(0, 1, 1); step(0, 1, 1);
      step(1, 1, 1);
      step(0, 1, 0); step(0, 1, 1); step(0, 1, 1); step(0, 1, 0);
      step(0, 0, 0);

      // Reset coincident with the fourth bit of a word.
      step(1, 0, 0);
      step(0, 1, 1); step(0, 1, 0); step(0, 1, 1);
      step(1, 1, 1);
      step(0, 0, 0);
      step(0, 1, 1);

      // Randomized traffic with sporadic resets and enable gaps.
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 39) == 0),
              1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 1)));
      end
      step(0, 0, 0);

      // Let the monitor drain the final expectation.
      @(negedge clk);
      #1;
      chk("pending_states", 32'(expq.size()), 32'(0));
      chk("pending_words",  32'(wq.size()),   32'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
